// File: rtl/eh2_posit_enc.sv
// eh2_posit_enc: packs decoded posit fields into a posit word through a two-stage valid/ready pipeline
module eh2_posit_enc #(
  parameter int POSIT_LEN  = 32,
  parameter int ES         = 3,
  parameter int REGIME_BW  = $clog2(POSIT_LEN),
  parameter int FRAC_W_GRS = POSIT_LEN - ES
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sgn,
  input  logic [REGIME_BW-1:0]  in_reg,
  input  logic [ES-1:0]         in_exp,
  input  logic [FRAC_W_GRS-1:0] in_fra,
  input  logic                  in_oflw,
  input  logic                  in_zero,
  input  logic                  in_nar,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [POSIT_LEN-1:0]  out_data
);
  localparam int LW = POSIT_LEN - 1;
  localparam int XW = 1 + ES + FRAC_W_GRS - 1 + POSIT_LEN;

  logic                 r1_valid;
  logic                 r1_sgn;
  logic                 r1_nar;
  logic [LW-1:0]        r1_l;
  logic                 r1_g;
  logic                 r1_st;
  logic                 r2_valid;
  logic [POSIT_LEN-1:0] r2_data;

  logic                 w_s2_load;
  logic                 w_acc;
  logic                 w_neg;
  logic                 w_spec;
  logic [REGIME_BW:0]   w_sh;
  logic [XW-1:0]        w_x;
  logic [XW-1:0]        w_v;
  logic [LW-1:0]        w_l;
  logic                 w_inc;
  logic [LW:0]          w_sum;
  logic [LW:0]          w_mag;
  logic [POSIT_LEN-1:0] w_out;

  assign w_s2_load = !r2_valid || out_ready;
  assign in_ready  = !r1_valid || w_s2_load;
  assign w_acc     = in_valid && in_ready;

  // The regime string is built by shifting a marker bit (the terminator) right by the run length:
  // k>=0 shifts in k+1 ones ahead of a 0, k<0 shifts in -k zeros ahead of a 1.
  assign w_neg  = in_reg[REGIME_BW-1];
  assign w_sh   = w_neg ? -{1'b1, in_reg} : {1'b0, in_reg} + (REGIME_BW+1)'(1);
  assign w_x    = {w_neg, in_exp, in_fra[FRAC_W_GRS-1:1], {POSIT_LEN{1'b0}}};
  assign w_v    = (w_x >> w_sh) | (w_neg ? '0 : ~({XW{1'b1}} >> w_sh));
  assign w_spec = in_nar || in_zero || in_oflw;
  assign w_l    = in_zero ? '0 : in_oflw ? (w_neg ? LW'(1) : {LW{1'b1}}) : w_v[XW-1 -: LW];

  // Stage 2 rounding: nearest-even, saturating at maxpos, then sign application.
  assign w_inc  = r1_g && (r1_st || r1_l[0]);
  assign w_sum  = {1'b0, r1_l} + {{LW{1'b0}}, w_inc};
  assign w_mag  = w_sum[LW] ? {1'b0, {LW{1'b1}}} : w_sum;
  assign w_out  = r1_nar ? {1'b1, {LW{1'b0}}} : r1_sgn ? -w_mag : w_mag;

  // Stage 1: capture truncated magnitude with guard/sticky on accept, drain when stage 2 takes it.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r1_valid <= 1'b0;
      r1_sgn   <= 1'b0;
      r1_nar   <= 1'b0;
      r1_l     <= '0;
      r1_g     <= 1'b0;
      r1_st    <= 1'b0;
    end else if (w_acc) begin
      r1_valid <= 1'b1;
      r1_sgn   <= in_sgn && !in_zero;
      r1_nar   <= in_nar;
      r1_l     <= w_l;
      r1_g     <= !w_spec && w_v[XW-1-LW];
      r1_st    <= !w_spec && (|w_v[XW-2-LW:0] || in_fra[0]);
    end else if (w_s2_load) begin
      r1_valid <= 1'b0;
    end
  end

  // Stage 2: output register, loads whenever empty or the consumer takes the current word.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r2_valid <= 1'b0;
      r2_data  <= '0;
    end else if (w_s2_load) begin
      r2_valid <= r1_valid;
      r2_data  <= r1_valid ? w_out : r2_data;
    end
  end

  assign out_valid = r2_valid;
  assign out_data  = r2_data;
endmodule
